fb_write_drain: RTL and testbench
=================================

Name: fb_write_drain

Overview:
- Consumer end of the brush pixel-write FIFO: pops (x, y, rgb) write requests, bounds-checks them, converts them to a linear framebuffer address and issues single-pixel writes to the framebuffer RAM write port.
- Sits between the write FIFO read side and the framebuffer memory arbiter; the arbiter grants the write port when the display read path does not need it.

Parameters:
- RESOLUTION_H, 640, visible pixels per line; legal x is 0..RESOLUTION_H-1
- RESOLUTION_V, 480, visible lines; legal y is 0..RESOLUTION_V-1
- HPOS_WIDTH, 10, width of the x coordinate
- VPOS_WIDTH, 10, width of the y coordinate
- ADDR_WIDTH, $clog2(RESOLUTION_H*RESOLUTION_V), framebuffer address width (19 at defaults)
- CLEAR_COLOR, 3'b000, fill colour for the clear sweep (FB_CLEAR_EN only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifoempty  in  1  write FIFO empty flag
- fifopop  out  1  one-cycle FIFO read strobe
- fifo_x  in  HPOS_WIDTH  popped x; valid the cycle after fifopop
- fifo_y  in  VPOS_WIDTH  popped y; valid the cycle after fifopop
- fifo_rgb  in  3  popped colour; valid the cycle after fifopop
- mem_grant  in  1  arbiter grant for the framebuffer write port
- mem_we  out  1  write request; held until granted
- mem_addr  out  ADDR_WIDTH  linear address y*RESOLUTION_H+x
- mem_wdata  out  3  pixel colour
- busy  out  1  high in every state except IDLE
- drop_count  out  16  saturating count of out-of-range requests discarded
- clear_req  in  1  start a full-screen clear (FB_CLEAR_EN only)

Behaviour:
- Reset (asynchronous): state=IDLE; fifopop=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, drop_count=0.
- All outputs are registered.
- FSM states:
  - IDLE: if !fifoempty, drive fifopop=1 for one cycle and go to FETCH; otherwise stay.
  - FETCH: latch fifo_x, fifo_y, fifo_rgb.
    - If x>=RESOLUTION_H or y>=RESOLUTION_V: drop_count+=1 (saturates at 16'hFFFF), return to IDLE, no write.
    - Else go to CALC.
  - CALC: register mem_addr = y*RESOLUTION_H + x, computed at ADDR_WIDTH width with no truncation of legal values; mem_wdata = rgb; set mem_we=1; go to WRITE.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable while mem_grant=0. The write completes on the first edge with mem_we&&mem_grant.
    - Next cycle mem_we=0.
    - If !fifoempty, assert fifopop in that same cycle and go to FETCH (back-to-back).
    - Else go to IDLE.
- Latency: pop to mem_we = 2 cycles; a pixel issues at most every 3 cycles with continuous grant.
- fifopop is never asserted while fifoempty=1 and never in two consecutive cycles.
- mem_grant while mem_we=0 is ignored.
- Reset mid-operation aborts any pending write; the popped entry is lost, which is acceptable.
- Boundary: x=RESOLUTION_H-1, y=RESOLUTION_V-1 is written at address RESOLUTION_H*RESOLUTION_V-1 (307199 at defaults); x=RESOLUTION_H is dropped.

Optional Feature:
- Macro FB_CLEAR_EN.
- With the macro:
  - Adds clear_req input and a CLEAR state.
  - IDLE checks clear_req before fifoempty; clear has priority.
  - CLEAR writes CLEAR_COLOR to addresses 0..RESOLUTION_H*RESOLUTION_V-1 in ascending order, one per granted cycle, using the same mem_we/mem_grant handshake.
  - The FIFO is not popped during CLEAR; busy=1; return to IDLE after the last address.
  - clear_req during CLEAR is ignored.
- Without the macro: no clear_req port, no CLEAR state; the FSM is exactly as above.

Decomposition:
- Shared package fb_pkg: RESOLUTION_H/V defaults, FB_DEPTH=RESOLUTION_H*RESOLUTION_V, ADDR_WIDTH, and the state enum (IDLE, FETCH, CALC, WRITE, CLEAR).
- One natural sub-module: fb_addr_calc, a registered y*RESOLUTION_H+x with a one-cycle latency, reusable by the display read side.

Test Plan:
- Push (5,3,3'b101); grant always 1 -> one write with mem_addr=1925, mem_wdata=5, exactly 2 cycles after fifopop.
- Push (640,0,1) then (0,480,1) -> no mem_we; drop_count=2; busy returns to 0.
- Push (639,479,7) with mem_grant held low for 10 cycles -> mem_we, mem_addr=307199 and mem_wdata stable all 10 cycles; a single write on the grant cycle.
- Preload 4 entries, grant=1 -> 4 writes with a 3-cycle spacing; fifopop never seen with fifoempty=1.
- Assert reset while in WRITE -> mem_we=0 immediately (asynchronous), drop_count=0, state IDLE.
- FB_CLEAR_EN: pulse clear_req with 2 FIFO entries pending -> 307200 writes of CLEAR_COLOR at ascending addresses, then the 2 FIFO writes.

Source files
------------

// File: rtl/fb_write_drain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_pkg - framebuffer geometry defaults and write-drain FSM state encoding |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fb_pkg;

    localparam int FB_RES_H      = 640;
    localparam int FB_RES_V      = 480;
    localparam int FB_DEPTH      = FB_RES_H * FB_RES_V;
    localparam int FB_ADDR_WIDTH = $clog2(FB_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } fb_state_e;

    function automatic int fb_addr_width(input int h, input int v);
        return $clog2(h * v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_drain_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_write_drain_if - FIFO read side, framebuffer write port and status      |
// | Rev 1.0 (clear_req exists only when FB_CLEAR_EN is defined)                |
// +--------------------------------------------------------------------------+
interface fb_write_drain_if #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_WIDTH
);
    logic                  fifoempty;
    logic                  fifopop;
    logic [HPOS_WIDTH-1:0] fifo_x;
    logic [VPOS_WIDTH-1:0] fifo_y;
    logic [2:0]            fifo_rgb;
    logic                  mem_grant;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [2:0]            mem_wdata;
    logic                  busy;
    logic [15:0]           drop_count;
`ifdef FB_CLEAR_EN
    logic                  clear_req;
`endif

    modport master (
        input  fifoempty, fifo_x, fifo_y, fifo_rgb, mem_grant,
`ifdef FB_CLEAR_EN
        input  clear_req,
`endif
        output fifopop, mem_we, mem_addr, mem_wdata, busy, drop_count
    );

    modport slave (
        output fifoempty, fifo_x, fifo_y, fifo_rgb, mem_grant,
`ifdef FB_CLEAR_EN
        output clear_req,
`endif
        input  fifopop, mem_we, mem_addr, mem_wdata, busy, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_addr_calc - registered linear address y*RESOLUTION_H+x, 1-cycle latency |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int RESOLUTION_H = FB_RES_H,
    parameter int HPOS_WIDTH   = 10,
    parameter int VPOS_WIDTH   = 10,
    parameter int ADDR_WIDTH   = FB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [HPOS_WIDTH-1:0] x_i,
    input  logic [VPOS_WIDTH-1:0] y_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    logic [ADDR_WIDTH-1:0] addr_q;

    // Operands widened to the full address width so legal products never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (en_i) begin
            addr_q <= ADDR_WIDTH'(y_i) * ADDR_WIDTH'(RESOLUTION_H) + ADDR_WIDTH'(x_i);
        end
    end

    assign addr_o = addr_q;
endmodule
`default_nettype wire

// File: rtl/fb_write_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_write_drain - pops pixel writes, bounds-checks, issues framebuffer writes|
// | Rev 1.0 (define FB_CLEAR_EN for the full-screen clear sweep)               |
// +--------------------------------------------------------------------------+
module fb_write_drain
    import fb_pkg::*;
#(
    parameter int RESOLUTION_H = FB_RES_H,
    parameter int RESOLUTION_V = FB_RES_V,
    parameter int HPOS_WIDTH   = 10,
    parameter int VPOS_WIDTH   = 10,
    parameter int ADDR_WIDTH   = fb_addr_width(RESOLUTION_H, RESOLUTION_V)
`ifdef FB_CLEAR_EN
    ,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    fb_write_drain_if.master bus
);
    fb_state_e             state_q, state_d;
    logic                  fifopop_q, fifopop_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic [2:0]            wdata_q, wdata_d;
    logic [15:0]           drop_q, drop_d;
    logic                  calc_en;
    logic [HPOS_WIDTH-1:0] calc_x;
    logic [VPOS_WIDTH-1:0] calc_y;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic                  in_range;
    logic                  granted;

    // Popped data is valid in CALC, the cycle after the pop strobe.
    assign in_range = (32'(bus.fifo_x) < 32'(RESOLUTION_H)) &&
                      (32'(bus.fifo_y) < 32'(RESOLUTION_V));
    assign granted  = mem_we_q && bus.mem_grant;

`ifdef FB_CLEAR_EN
    logic [HPOS_WIDTH-1:0] clr_x_q, clr_x_d, clr_nx;
    logic [VPOS_WIDTH-1:0] clr_y_q, clr_y_d, clr_ny;
    logic                  clr_eol, clr_last;

    assign clr_eol  = (clr_x_q == HPOS_WIDTH'(RESOLUTION_H - 1));
    assign clr_last = clr_eol && (clr_y_q == VPOS_WIDTH'(RESOLUTION_V - 1));
    assign clr_nx   = clr_eol ? '0 : clr_x_q + 1'b1;
    assign clr_ny   = clr_eol ? clr_y_q + 1'b1 : clr_y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
        end else begin
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef FB_CLEAR_EN
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                end else
`endif
                if (!bus.fifoempty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CALC;
            ST_CALC:  state_d = in_range ? ST_WRITE : ST_IDLE;
            ST_WRITE: begin
                if (granted) begin
                    state_d = bus.fifoempty ? ST_IDLE : ST_FETCH;
                end
            end
`ifdef FB_CLEAR_EN
            ST_CLEAR: begin
                if (granted && clr_last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifopop_d = 1'b0;
        mem_we_d  = mem_we_q;
        wdata_d   = wdata_q;
        drop_d    = drop_q;
        calc_en   = 1'b0;
        calc_x    = bus.fifo_x;
        calc_y    = bus.fifo_y;
`ifdef FB_CLEAR_EN
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FB_CLEAR_EN
                if (bus.clear_req) begin
                    calc_en  = 1'b1;
                    calc_x   = '0;
                    calc_y   = '0;
                    clr_x_d  = '0;
                    clr_y_d  = '0;
                    mem_we_d = 1'b1;
                    wdata_d  = CLEAR_COLOR;
                end else
`endif
                if (!bus.fifoempty) begin
                    fifopop_d = 1'b1;
                end
            end
            ST_CALC: begin
                if (in_range) begin
                    calc_en  = 1'b1;
                    mem_we_d = 1'b1;
                    wdata_d  = bus.fifo_rgb;
                end else if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            ST_WRITE: begin
                if (granted) begin
                    mem_we_d  = 1'b0;
                    fifopop_d = !bus.fifoempty;
                end
            end
`ifdef FB_CLEAR_EN
            ST_CLEAR: begin
                if (granted) begin
                    if (clr_last) begin
                        mem_we_d = 1'b0;
                    end else begin
                        calc_en = 1'b1;
                        calc_x  = clr_nx;
                        calc_y  = clr_ny;
                        clr_x_d = clr_nx;
                        clr_y_d = clr_ny;
                    end
                end
            end
`endif
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifopop_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            wdata_q   <= 3'b000;
            drop_q    <= 16'd0;
        end else begin
            fifopop_q <= fifopop_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            wdata_q   <= wdata_d;
            drop_q    <= drop_d;
        end
    end

    fb_addr_calc #(
        .RESOLUTION_H (RESOLUTION_H),
        .HPOS_WIDTH   (HPOS_WIDTH),
        .VPOS_WIDTH   (VPOS_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_calc (
        .clk    (clk),
        .reset  (reset),
        .en_i   (calc_en),
        .x_i    (calc_x),
        .y_i    (calc_y),
        .addr_o (calc_addr)
    );

    assign bus.fifopop    = fifopop_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = calc_addr;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_fb_write_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_write_drain - randomized bench with a queue-based reference model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fb_write_drain;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int HW = 10;
    localparam int VW = 10;
    localparam int AW = 19;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fb_write_drain_if #(.HPOS_WIDTH(HW), .VPOS_WIDTH(VW), .ADDR_WIDTH(AW)) bus ();

    fb_write_drain #(
        .RESOLUTION_H (H),
        .RESOLUTION_V (V),
        .HPOS_WIDTH   (HW),
        .VPOS_WIDTH   (VW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int x; int y; int rgb; } px_t;
    typedef struct { int due; bit legal; int addr; int rgb; } ev_t;

    px_t fifo_q[$];   // contents of the write FIFO
    ev_t ev_q[$];     // popped requests and the cycle their effect must appear
    int  wr_cyc[$];
    int  cyc = 0, n_cmp = 0, n_bad = 0, exp_drop = 0, n_writes = 0;
    int  grant_low = 0, grant_pct = 100, stall_cnt = 0;
    int  pop_cyc = 0, rise_cyc = 0, w_addr = -1, w_rgb = -1;
    logic prev_pop = 1'b0, prev_we = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        bit exp_we;
        while (ev_q.size() != 0 && !ev_q[0].legal && cyc >= ev_q[0].due) begin
            if (exp_drop < 65535) exp_drop++;
            void'(ev_q.pop_front());
        end
        exp_we = (ev_q.size() != 0) && ev_q[0].legal && (cyc >= ev_q[0].due);
        chk("mem_we", bus.mem_we, exp_we);
        chk("drop_count", bus.drop_count, exp_drop);
        chk("pop_repeat", bus.fifopop & prev_pop, 0);
        if (bus.fifopop) chk("pop_when_empty", bus.fifoempty, 0);
        if (bus.fifopop || bus.mem_we) chk("busy", bus.busy, 1);
        if (exp_we) begin
            chk("mem_addr", bus.mem_addr, ev_q[0].addr);
            chk("mem_wdata", bus.mem_wdata, ev_q[0].rgb);
            if (!prev_we) rise_cyc = cyc;
            if (bus.mem_grant) begin
                w_addr = ev_q[0].addr;
                w_rgb  = ev_q[0].rgb;
                n_writes++;
                wr_cyc.push_back(cyc);
                void'(ev_q.pop_front());
            end else begin
                stall_cnt++;
            end
        end
        if (bus.fifopop) pop_cyc = cyc;
        prev_pop = bus.fifopop;
        prev_we  = bus.mem_we;
    endtask

    // One clock: FIFO reacts to a pop strobe seen at the edge, then check at negedge.
    task automatic tick();
        logic pop;
        px_t  p;
        ev_t  e;
        pop = bus.fifopop;
        @(posedge clk);
        cyc++;
        #1;
        if (pop && !reset && fifo_q.size() != 0) begin
            p = fifo_q.pop_front();
            bus.fifo_x   = HW'(p.x);
            bus.fifo_y   = VW'(p.y);
            bus.fifo_rgb = 3'(p.rgb);
            e.due   = cyc + 1;
            e.legal = (p.x < H) && (p.y < V);
            e.addr  = p.y * H + p.x;
            e.rgb   = p.rgb;
            ev_q.push_back(e);
        end
        bus.fifoempty = (fifo_q.size() == 0);
        if (grant_low > 0) begin
            bus.mem_grant = 1'b0;
            grant_low--;
        end else begin
            bus.mem_grant = ($urandom_range(99) < grant_pct);
        end
        @(negedge clk);
        if (!reset) compare();
    endtask

    task automatic push(input int x, input int y, input int rgb);
        px_t p;
        p.x = x; p.y = y; p.rgb = rgb;
        fifo_q.push_back(p);
        bus.fifoempty = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || ev_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wbase;
        bus.fifoempty = 1'b1;
        bus.fifo_x    = '0;
        bus.fifo_y    = '0;
        bus.fifo_rgb  = '0;
        bus.mem_grant = 1'b0;
`ifdef FB_CLEAR_EN
        bus.clear_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_fifopop", bus.fifopop, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop", bus.drop_count, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single in-range pixel with permanent grant
        grant_pct = 100;
        push(5, 3, 5);
        wait_idle(50);
        chk("t1_latency", rise_cyc - pop_cyc, 2);
        chk("t1_addr", w_addr, 1925);
        chk("t1_wdata", w_rgb, 5);
        chk("t1_writes", n_writes, 1);

        // Both coordinates out of range on their own
        push(640, 0, 1);
        push(0, 480, 1);
        wait_idle(50);
        chk("t2_drops", bus.drop_count, 2);
        chk("t2_busy", bus.busy, 0);
        chk("t2_writes", n_writes, 1);

        // Bottom-right corner with grant withheld
        stall_cnt = 0;
        push(639, 479, 7);
        grant_low = 12;
        wait_idle(60);
        chk("t3_stall", stall_cnt, 10);
        chk("t3_addr", w_addr, 307199);
        chk("t3_wdata", w_rgb, 7);
        chk("t3_writes", n_writes, 2);

        // Four preloaded entries drain back-to-back
        wr_cyc.delete();
        for (int i = 0; i < 4; i++)
            push($urandom_range(H - 1), $urandom_range(V - 1), $urandom_range(7));
        wait_idle(60);
        chk("t4_writes", wr_cyc.size(), 4);
        for (int i = 1; i < 4 && i < wr_cyc.size(); i++)
            chk("t4_spacing", wr_cyc[i] - wr_cyc[i-1], 3);

        // Random traffic, including out-of-range and stalled grants
        grant_pct = 60;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 35)
                push($urandom_range(700), $urandom_range(520), $urandom_range(7));
            tick();
        end
        wait_idle(3000);
        chk("rand_idle_busy", bus.busy, 0);

        // Asynchronous reset while a write is pending
        grant_pct = 100;
        push(100, 200, 3);
        grant_low = 30;
        n = 0;
        while (!bus.mem_we && n < 10) begin
            tick();
            n++;
        end
        chk("pre_reset_we", bus.mem_we, 1);
        reset = 1'b1;
        #1;
        chk("arst_mem_we", bus.mem_we, 0);
        chk("arst_drop", bus.drop_count, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_addr", bus.mem_addr, 0);
        ev_q.delete();
        exp_drop  = 0;
        grant_low = 0;
        repeat (2) tick();
        reset    = 1'b0;
        prev_pop = 1'b0;
        prev_we  = 1'b0;
        tick();

        // Recovery after reset
        wbase = n_writes;
        push(1, 1, 6);
        wait_idle(50);
        chk("post_reset_writes", n_writes - wbase, 1);
        chk("post_reset_addr", w_addr, 641);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
